// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types.
//   word_t      - 32-bit machine word
//   ramstate_t  - handshake state reported by the unified RAM
//   arb_state_t - mem_arbiter FSM state, exported so benches can probe it
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } arb_state_t;

    // Width of the data-streak counter; STREAK_LIMIT must fit in it.
    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single unified RAM port between instruction fetch
// and the data requester.
//
// Ports:
//   CLK, nRST              clock, async active-low reset
//   iREN, iaddr            fetch request / word address
//   iwait, iload           fetch stall (0 only on completion) / read data
//   dREN, dWEN             data read / write request (write wins if both)
//   daddr, dstore          data address / write value
//   dwait, dload           data stall (0 only on completion) / read data
//   ramREN, ramWEN         RAM enables
//   ramaddr, ramstore      RAM address / write data
//   ramload, ramstate      RAM read data / RAM handshake state
//   dbg_state, dbg_streak  FSM state and streak counter, for observation
//
// Handshake: a requester raises its request and holds request, address and
// store data stable while its wait is 1. Its wait drops to 0 for exactly the
// one cycle in which the RAM reports ACCESS, and load data is valid only in
// that cycle. Dropping the request mid-transfer aborts without completion.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STREAK_LIMIT = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                iREN,
    input  word_t               iaddr,
    output logic                iwait,
    output word_t               iload,
    input  logic                dREN,
    input  logic                dWEN,
    input  word_t               daddr,
    input  word_t               dstore,
    output logic                dwait,
    output word_t               dload,
    output logic                ramREN,
    output logic                ramWEN,
    output word_t               ramaddr,
    output word_t               ramstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate,
    output arb_state_t          dbg_state,
    output logic [STREAK_W-1:0] dbg_streak
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STREAK_LIMIT);

    arb_state_t          state, next_state;
    logic [STREAK_W-1:0] streak, next_streak;
    logic                d_req;

    assign d_req      = dREN | dWEN;
    assign dbg_state  = state;
    assign dbg_streak = streak;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= next_state;
            streak <= next_streak;
        end
    end

    always_comb begin
        next_state  = state;
        next_streak = streak;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;

        unique case (state)
            IDLE: begin
                // Data has priority unless a waiting fetch has already seen
                // STREAK_LIMIT data grants in a row.
                if (d_req && (!iREN || streak < LIMIT)) begin
                    next_state = D_XFER;
                    if (iREN && streak < LIMIT)
                        next_streak = streak + 1'b1;
                end else if (iREN) begin
                    next_state  = I_XFER;
                    next_streak = '0;
                end
            end

            I_XFER: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    // Abort: enables already low, no completion.
                    next_state = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        next_state = IDLE;
                    end
                end
            end

            D_XFER: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = ~dWEN;
                    if (ramstate == ACCESS) begin
                        dwait      = 1'b0;
                        dload      = dWEN ? '0 : ramload;
                        next_state = IDLE;
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single unified RAM port between the instruction-fetch requester and the data requester of the pipelined datapath.
- Grants one requester at a time and holds the grant until the RAM reports ACCESS.
- Data requests have priority; a streak limit prevents fetch starvation.
- Generates the per-requester wait signals that the caches turn into ihit/dhit.

Parameters:
- STREAK_LIMIT, 4: maximum consecutive data grants issued while a fetch is pending; range 1..15.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request; held until iwait=0.
- iaddr  in  32  instruction word address (word_t).
- iwait  out  1  instruction stall; 0 only in the cycle its read completes.
- iload  out  32  instruction read data; valid when iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address (word_t).
- dstore  in  32  data write value.
- dwait  out  1  data stall; 0 only in the cycle its access completes.
- dload  out  32  data read data; valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset values:
  - state IDLE, streak counter 0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - Reset asserted mid-transfer forces these values immediately, independent of CLK.
- States: IDLE, I_XFER, D_XFER.
- IDLE:
  - RAM enables are 0.
  - If (dREN|dWEN) and (!iREN or streak<STREAK_LIMIT), go to D_XFER.
  - Else if iREN, go to I_XFER.
  - Else stay in IDLE.
- Latency: RAM is first driven in the cycle after the request is seen in IDLE (one-cycle arbitration).
- I_XFER:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0 and iload=ramload combinationally that cycle; next state IDLE.
- D_XFER:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN=1: ramWEN=1, ramREN=0. dWEN wins when dREN and dWEN are both set.
  - Else: ramREN=1, ramWEN=0.
  - When ramstate==ACCESS: dwait=0 and dload=ramload (0 on writes); next state IDLE.
- FREE, BUSY and ERROR in an XFER state: stay in the state, keep driving, wait stays 1. ERROR is retried and never completes.
- Abort: if the owner drops its request while in XFER, RAM enables go to 0 that same cycle (combinational) and the next state is IDLE. No completion is signalled.
- Return to IDLE after every completion is mandatory. The one-cycle bubble prevents re-granting a request the requester has not yet withdrawn.
- Streak counter (4 bits):
  - Increments on each IDLE->D_XFER transition taken while iREN=1; saturates at STREAK_LIMIT.
  - Clears on each IDLE->I_XFER transition.
  - Unchanged otherwise.
- Non-owner wait is always 1. iwait and dwait are never both 0 in the same cycle.
- Address and store data pass through unregistered; requesters must hold them stable while their wait=1.

Decomposition:
- cpu_types_pkg already provides word_t and ramstate_t.
- Add arb_state_t {IDLE, I_XFER, D_XFER} to cpu_types_pkg so the bench can probe state symbolically.
- Single module with next-state logic, state register and streak register. No sub-module; the arbitration is too small to justify one.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40; ramstate BUSY 2 cycles then ACCESS with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C220004 only in the ACCESS cycle; IDLE the next cycle.
- Simultaneous requests: iREN=1 and dREN=1, daddr=0x100 -> D_XFER granted first; I_XFER granted after the IDLE bubble; iwait held 1 throughout the data access.
- Write priority: dREN=1, dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 on ACCESS.
- Starvation: iREN held 1 with data requests back-to-back, STREAK_LIMIT=4 -> exactly 4 data grants, then one fetch grant; counter reads 0 afterwards.
- Abort and ERROR: ramstate=ERROR for 3 cycles -> wait stays 1 and the transfer is retried. Owner then drops its request -> ramREN=0 that cycle and IDLE next.
- Reset mid-transfer: nRST pulsed low between clock edges during D_XFER -> all outputs take reset values immediately; a fresh request afterwards re-arbitrates from IDLE.
